spi_sram_port: RTL and testbench

Serial SRAM port that sits directly under the CPU core and turns single-cycle read/write requests into SPI mode-0 transactions on an external 23LC512-class SRAM. It holds both program and data memory. It latches the request, then shifts out command, address and (for writes) data. Read data is assembled into a little-endian word, and `busy` is held until the word is valid, so the core only has to wait for `busy` low.

---
 rtl/spi_sram_port.sv | 163 ++++++++++++++++
 tb/tb_spi_sram_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_port.sv
// rtl/spi_sram_port.sv - CPU request to SPI mode-0 serial SRAM bridge (read/write, little-endian words)
// Define SPI_SRAM_CLK_DIV4_EN to run the SPI clock at clk/4 instead of clk/2.
module spi_sram_port #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_BITS-1:0]          addr_in,
    input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
    input  logic                          start_read,
    input  logic                          start_write,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          busy,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    output logic                          spi_mosi,
    input  logic                          spi_miso
);

    localparam int DW = 8 * DATA_WIDTH_BYTES;
    localparam int N  = 8 + ADDR_BITS + DW;
    localparam int CW = $clog2(N + 1);
`ifdef SPI_SRAM_CLK_DIV4_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif
    localparam logic [0:0]    PH_LAST  = 1'(P - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_END
    } state_t;

    // Byte order on the wire is least-significant byte first.
    function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            r[8*i +: 8] = w[8*(DATA_WIDTH_BYTES-1-i) +: 8];
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [DW-1:0] rx_q, rx_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [0:0]    ph_q, ph_d;
    logic          is_read_q, is_read_d;
    logic          busy_q, busy_d;
    logic          select_q, select_d;
    logic          clk_out_q, clk_out_d;
    logic          mosi_q, mosi_d;

    logic [N-1:0]  frame_load;
    logic [DW-1:0] rx_next;

    assign frame_load = {(start_write ? 8'h02 : 8'h03), addr_in,
                         (start_write ? swap_bytes(data_in) : {DW{1'b0}})};
    assign rx_next    = {rx_q[DW-2:0], spi_miso};

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        ph_d       = ph_q;
        is_read_d  = is_read_q;
        busy_d     = busy_q;
        select_d   = select_q;
        clk_out_d  = clk_out_q;
        mosi_d     = mosi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_write || start_read) begin
                    state_d   = ST_SHIFT;
                    is_read_d = !start_write;
                    mosi_d    = frame_load[N-1];
                    sreg_d    = {frame_load[N-2:0], 1'b0};
                    bit_cnt_d = '0;
                    ph_d      = '0;
                    busy_d    = 1'b1;
                    select_d  = 1'b0;
                    clk_out_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!clk_out_q) begin
                        clk_out_d = 1'b1;
                    end else begin
                        // Edge ending the high phase: sample MISO, then next bit or finish.
                        rx_d      = rx_next;
                        clk_out_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d  = ST_END;
                            select_d = 1'b1;
                            mosi_d   = 1'b0;
                            if (is_read_q) begin
                                data_out_d = swap_bytes(rx_next);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                            mosi_d    = sreg_q[N-1];
                            sreg_d    = {sreg_q[N-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_END: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            ph_q       <= '0;
            is_read_q  <= 1'b0;
            busy_q     <= 1'b0;
            select_q   <= 1'b1;
            clk_out_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            ph_q       <= ph_d;
            is_read_q  <= is_read_d;
            busy_q     <= busy_d;
            select_q   <= select_d;
            clk_out_q  <= clk_out_d;
            mosi_q     <= mosi_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign spi_select  = select_q;
    assign spi_clk_out = clk_out_q;
    assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_sram_port.sv
// tb/tb_spi_sram_port.sv - scoreboard bench for spi_sram_port with an SPI SRAM slave model
module tb_spi_sram_port;

`ifdef SPI_SRAM_CLK_DIV4_EN
    localparam int P        = 2;
    localparam int BUSY_LEN = 161;
    localparam int SEL_LEN  = 160;
`else
    localparam int P        = 1;
    localparam int BUSY_LEN = 81;
    localparam int SEL_LEN  = 80;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic        start_read;
    logic        start_write;
    logic [15:0] data_out;
    logic        busy;
    logic        spi_select;
    logic        spi_clk_out;
    logic        spi_mosi;
    logic        spi_miso;

    spi_sram_port #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .start_read (start_read),
        .start_write(start_write),
        .data_out   (data_out),
        .busy       (busy),
        .spi_select (spi_select),
        .spi_clk_out(spi_clk_out),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    logic [39:0] exp_frame_q[$];
    logic [15:0] exp_dout_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] slave_resp = 16'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Slave model and monitor: captures MOSI on SPI rising edges, drives MISO in low phases.
    logic        prev_sel  = 1'b1;
    logic        prev_clk  = 1'b0;
    logic        prev_busy = 1'b0;
    int          rise_cnt  = 0;
    int          sel_cnt   = 0;
    int          busy_cnt  = 0;
    int          run_len   = 0;
    logic [39:0] frame     = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!spi_select) begin
                if (prev_sel) begin
                    frame    = '0;
                    rise_cnt = 0;
                    sel_cnt  = 0;
                    run_len  = 1;
                end else if (spi_clk_out != prev_clk) begin
                    check("clk_phase_len", run_len, P);
                    run_len = 1;
                end else begin
                    run_len++;
                end
                sel_cnt++;
                if (spi_clk_out && !prev_clk) begin
                    frame = {frame[38:0], spi_mosi};
                    rise_cnt++;
                end
                if (!spi_clk_out) begin
                    spi_miso = (rise_cnt >= 24 && rise_cnt < 40) ? slave_resp[39-rise_cnt] : 1'b0;
                end
            end else if (!prev_sel) begin
                check("clk_phase_len", run_len, P);
                check("frame_bits", rise_cnt, 40);
                check("select_low", sel_cnt, SEL_LEN);
                if (exp_frame_q.size() > 0) begin
                    check("mosi_frame", frame, exp_frame_q.pop_front());
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: actual %0h required none", frame);
                end
            end
            if (busy) begin
                if (!prev_busy) busy_cnt = 0;
                busy_cnt++;
            end else if (prev_busy) begin
                check("busy_len", busy_cnt, BUSY_LEN);
                if (exp_dout_q.size() > 0) begin
                    check("data_out", data_out, exp_dout_q.pop_front());
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_busy: actual %0h required none", data_out);
                end
            end
        end
        prev_sel  = spi_select;
        prev_clk  = spi_clk_out;
        prev_busy = busy;
    end

    // Issues one request, then waits (bounded) for busy to fall; inj>0 pulses a stray read mid-transaction.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] resp, input logic [39:0] exp_frame,
                           input logic [15:0] exp_d, input int inj);
        int cyc;
        slave_resp = resp;
        exp_frame_q.push_back(exp_frame);
        exp_dout_q.push_back(exp_d);
        addr_in     = a;
        data_in     = d;
        start_read  = rd;
        start_write = wr;
        @(posedge clk);
        #1;
        start_read  = 1'b0;
        start_write = 1'b0;
        addr_in     = 16'h0;
        data_in     = 16'h0;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!busy) break;
            if (cyc == inj) begin
                start_read = 1'b1;
                addr_in    = 16'hFFFF;
            end else if (cyc == inj + 1) begin
                start_read = 1'b0;
                addr_in    = 16'h0;
            end
        end
        check("busy_timeout", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"}, spi_select, 1'b1);
        check({tag, "_clk"}, spi_clk_out, 1'b0);
        check({tag, "_mosi"}, spi_mosi, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_data_out"}, data_out, 16'h0);
    endtask

    initial begin
        rst         = 1'b1;
        addr_in     = 16'h0;
        data_in     = 16'h0;
        start_read  = 1'b0;
        start_write = 1'b0;
        spi_miso    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 16'hABCD, 40'h03_1234_0000, 16'hCDAB, 0);
        run_txn(1'b0, 1'b1, 16'h00FE, 16'hBEEF, 16'h0000, 40'h02_00FE_EFBE, 16'hCDAB, 0);
        run_txn(1'b1, 1'b1, 16'h0010, 16'h5555, 16'h0000, 40'h02_0010_5555, 16'hCDAB, 0);
        run_txn(1'b0, 1'b1, 16'h0420, 16'hA5C3, 16'h0000, 40'h02_0420_C3A5, 16'hCDAB, 10);
        run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h3412, 40'h03_1234_0000, 16'h1234, 0);

        // Abandoned read: no expectations queued, reset lands 30 cycles in.
        slave_resp = 16'h9999;
        addr_in    = 16'h4321;
        start_read = 1'b1;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        addr_in    = 16'h0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h5A0F, 40'h03_0002_0000, 16'h0F5A, 0);

        repeat (20) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("pending_frames", exp_frame_q.size(), 0);
        check("pending_words", exp_dout_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
